// File: rtl/return_stack_if.sv
// Control-unit <-> return-address stack signal bundle.
// The control unit drives requests through the master modport; the stack answers through the slave modport.
interface return_stack_if #(
  parameter int WIDTH = 8,
  parameter int PTR_W = 3
);
  logic [WIDTH-1:0] pc_in;
  logic             push;
  logic             pop;
  logic             err_clr;
  logic [WIDTH-1:0] ret_addr;
  logic             ret_load;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output pc_in, push, pop, err_clr,
    input  ret_addr, ret_load, count, empty, full, overflow, underflow
  );

  modport slave (
    input  pc_in, push, pop, err_clr,
    output ret_addr, ret_load, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/return_stack.sv
// Hardware return-address stack (LIFO) feeding the PC parallel-load port.
// Optional macro RAS_WRAP_EN makes the stack circular (push when full overwrites the oldest entry).
module return_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic          clk,
  input  logic          rst,
  return_stack_if.slave bus
);
  localparam int CW = PTR_W + 1;
  localparam logic [PTR_W:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top;
  logic [PTR_W:0]   count;
  logic [WIDTH-1:0] ret_addr;
  logic             ret_load;
  logic             overflow;
  logic             underflow;

  logic is_empty;
  logic is_full;
  logic do_pop;
  logic do_push;
  logic swap;
  logic over_ev;
  logic under_ev;

  // ptr is the next write slot modulo DEPTH; in non-wrap mode it equals count
  // (mod DEPTH), so one pointer serves both the linear and the circular build.
  always_comb begin
    is_empty = (count == '0);
    is_full  = (count == DEPTH_C);
    top      = ptr - PTR_W'(1);
    do_pop   = bus.pop && !is_empty;
    swap     = do_pop && bus.push;
    under_ev = bus.pop && is_empty;
`ifdef RAS_WRAP_EN
    do_push  = bus.push && !do_pop;
    over_ev  = 1'b0;
`else
    do_push  = bus.push && !do_pop && !is_full;
    over_ev  = bus.push && !bus.pop && is_full;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      count     <= '0;
      ret_addr  <= '0;
      ret_load  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      ret_load <= do_pop;
      if (do_pop) ret_addr <= mem[top];

      if (do_push) begin
        ptr <= ptr + PTR_W'(1);
        if (!is_full) count <= count + CW'(1);
      end else if (do_pop && !bus.push) begin
        ptr   <= top;
        count <= count - CW'(1);
      end

      // A new error in the clearing cycle takes priority over err_clr.
      overflow  <= over_ev  | (overflow  & ~bus.err_clr);
      underflow <= under_ev | (underflow & ~bus.err_clr);
    end
  end

  // Storage carries no reset; nothing reads it while the stack is empty.
  always_ff @(posedge clk) begin
    if (do_push)   mem[ptr] <= bus.pc_in;
    else if (swap) mem[top] <= bus.pc_in;
  end

  always_comb begin
    bus.ret_addr  = ret_addr;
    bus.ret_load  = ret_load;
    bus.count     = count;
    bus.empty     = is_empty;
    bus.full      = is_full;
    bus.overflow  = overflow;
    bus.underflow = underflow;
  end
endmodule
